// File: rtl/twowire_dtm_pkg.sv
// Shared definitions for the two-wire DTM serial communications slice:
// FSM state encoding and the odd-parity helper.
package twowire_dtm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CMD_PARITY,
    ST_CTURN,
    ST_DATA,
    ST_PARITY,
    ST_PARK,
    ST_TAIL
  } dtm_state_e;

  // Odd-parity bit of a zero-extended vector (zero extension leaves the XOR unchanged).
  function automatic logic odd_parity(input logic [31:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/twowire_dtm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module twowire_dtm_sat_counter #(
  parameter int W = 8
) (
  input  logic         dck,
  input  logic         drst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge dck or posedge drst) begin
    if (drst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/twowire_dtm_serial_comms_param.sv
// Two-wire DTM serial framing: start / command / parity / turnaround / data /
// parity / park / tail, with next-cycle DO/DOE pad values and odd parity.
// Optional saturating parity-error counter under TWOWIRE_DTM_SERIAL_ERRCNT_EN.
//
// state         | meaning
// IDLE          | wait for start bit (di_q=1)
// CMD           | shift in W_CMD command bits, MSB first
// CMD_PARITY    | check command parity, pick read/write
// CTURN         | counted turnaround before payload
// DATA          | payload bits until cmd_payload_end
// PARITY        | payload parity check (write) or drive (read)
// PARK          | read drives park bit 0
// TAIL          | N_TURN undriven cycles before IDLE
module twowire_dtm_serial_comms_param
  import twowire_dtm_pkg::*;
#(
  parameter int W_CMD    = 4,
  parameter int N_TURN   = 2,
  parameter int W_ERRCNT = 8
) (
  input  logic                dck,
  input  logic                drst,
  input  logic                di_q,
  output logic                do_nxt,
  output logic                doe_nxt,
  input  logic                connected,
  output logic [W_CMD-1:0]    cmd,
  output logic                cmd_vld,
  input  logic                cmd_payload_end,
  output logic                parity_err,
  output logic                wdata,
  output logic                wdata_vld,
  input  logic                rdata,
  output logic                rdata_rdy,
  output logic [W_ERRCNT-1:0] err_cnt,
  input  logic                err_clr
);

  localparam int CNT_MAX = (W_CMD > N_TURN) ? W_CMD : N_TURN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  dtm_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W_CMD-1:0] cmd_q, cmd_d;
  logic             wr_q, wr_d;
  logic             par_q, par_d;
  logic             exp_par;

  assign exp_par = odd_parity(32'(cmd_q));

  // Next state, shared counter, command shift, running parity and pad outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    wr_d       = wr_q;
    par_d      = 1'b1;
    cmd_vld    = 1'b0;
    parity_err = 1'b0;
    wdata_vld  = 1'b0;
    rdata_rdy  = 1'b0;
    do_nxt     = 1'b0;
    doe_nxt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (di_q) begin
          state_d = ST_CMD;
          cnt_d   = CW'(W_CMD - 1);
        end
      end
      ST_CMD: begin
        cmd_d = {cmd_q[W_CMD-2:0], di_q};
        if (cnt_q == '0) state_d = ST_CMD_PARITY;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_CMD_PARITY: begin
        if (di_q == exp_par) begin
          cmd_vld = 1'b1;
          wr_d    = exp_par;
          if (exp_par) begin
            state_d = ST_CTURN;
            cnt_d   = CW'(N_TURN - 1);
          end else if (N_TURN > 2) begin
            // Read loses two turnaround cycles so data lines up with the host.
            state_d = ST_CTURN;
            cnt_d   = CW'(N_TURN - 3);
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          parity_err = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_CTURN: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DATA: begin
        if (wr_q) begin
          wdata_vld = 1'b1;
          par_d     = par_q ^ di_q;
        end else begin
          rdata_rdy = 1'b1;
          doe_nxt   = 1'b1;
          do_nxt    = rdata;
          par_d     = par_q ^ rdata;
        end
        if (cmd_payload_end) state_d = ST_PARITY;
      end
      ST_PARITY: begin
        if (wr_q) begin
          if (di_q != par_q) begin
            parity_err = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_PARK;
          end
        end else begin
          doe_nxt = 1'b1;
          do_nxt  = par_q;
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        doe_nxt = ~wr_q;
        state_d = ST_TAIL;
        cnt_d   = CW'(N_TURN - 1);
      end
      ST_TAIL: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Link loss releases the pads and aborts the frame; pulses already due still fire.
    if (!connected) begin
      state_d   = ST_IDLE;
      do_nxt    = 1'b0;
      doe_nxt   = 1'b0;
      wdata_vld = 1'b0;
      rdata_rdy = 1'b0;
    end
  end

  // State, counter, command, direction and running parity registers.
  always_ff @(posedge dck or posedge drst) begin
    if (drst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      wr_q    <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      wr_q    <= wr_d;
      par_q   <= par_d;
    end
  end

  assign cmd   = cmd_q;
  assign wdata = di_q;

`ifdef TWOWIRE_DTM_SERIAL_ERRCNT_EN
  twowire_dtm_sat_counter #(.W(W_ERRCNT)) u_err_cnt (
    .dck  (dck),
    .drst (drst),
    .inc  (parity_err),
    .clr  (err_clr),
    .cnt  (err_cnt)
  );
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = {W_ERRCNT{1'b0}};
`endif

endmodule

// File: tb/tb_twowire_dtm_serial_comms_param.sv
// Bench for twowire_dtm_serial_comms_param: three instances (N_TURN=2,
// N_TURN=4, W_ERRCNT=2); frames are described at frame level and expanded
// into per-cycle expected pad/strobe values.
module tb_twowire_dtm_serial_comms_param;

  logic dck = 1'b0;
  always #5 dck = ~dck;

  logic drst;
  logic [2:0] di_v, pend_v, rd_v, conn_v, clr_v;
  logic [2:0] do_v, doe_v, vld_v, perr_v, wd_v, wv_v, rr_v;
  logic [2:0][3:0] cmd_v;
  logic [7:0] err_a, err_b;
  logic [1:0] err_c;

  int n_vec = 0;
  int n_err = 0;
  int exp_err [3];

  typedef struct {
    logic di, pend, rd, conn, clr, rst;
    logic e_do, e_doe, e_vld, e_perr, e_wv, e_rr;
    bit   chk_do, chk_cmd;
    logic [3:0] e_cmd;
  } cyc_t;

  twowire_dtm_serial_comms_param #(.W_CMD(4), .N_TURN(2), .W_ERRCNT(8)) dut_a (
    .dck(dck), .drst(drst), .di_q(di_v[0]), .do_nxt(do_v[0]), .doe_nxt(doe_v[0]),
    .connected(conn_v[0]), .cmd(cmd_v[0]), .cmd_vld(vld_v[0]), .cmd_payload_end(pend_v[0]),
    .parity_err(perr_v[0]), .wdata(wd_v[0]), .wdata_vld(wv_v[0]), .rdata(rd_v[0]),
    .rdata_rdy(rr_v[0]), .err_cnt(err_a), .err_clr(clr_v[0]));

  twowire_dtm_serial_comms_param #(.W_CMD(4), .N_TURN(4), .W_ERRCNT(8)) dut_b (
    .dck(dck), .drst(drst), .di_q(di_v[1]), .do_nxt(do_v[1]), .doe_nxt(doe_v[1]),
    .connected(conn_v[1]), .cmd(cmd_v[1]), .cmd_vld(vld_v[1]), .cmd_payload_end(pend_v[1]),
    .parity_err(perr_v[1]), .wdata(wd_v[1]), .wdata_vld(wv_v[1]), .rdata(rd_v[1]),
    .rdata_rdy(rr_v[1]), .err_cnt(err_b), .err_clr(clr_v[1]));

  twowire_dtm_serial_comms_param #(.W_CMD(4), .N_TURN(2), .W_ERRCNT(2)) dut_c (
    .dck(dck), .drst(drst), .di_q(di_v[2]), .do_nxt(do_v[2]), .doe_nxt(doe_v[2]),
    .connected(conn_v[2]), .cmd(cmd_v[2]), .cmd_vld(vld_v[2]), .cmd_payload_end(pend_v[2]),
    .parity_err(perr_v[2]), .wdata(wd_v[2]), .wdata_vld(wv_v[2]), .rdata(rd_v[2]),
    .rdata_rdy(rr_v[2]), .err_cnt(err_c), .err_clr(clr_v[2]));

  task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t x;
    x.di = 1'b0; x.pend = 1'($urandom); x.rd = 1'($urandom);
    x.conn = 1'b1; x.clr = 1'b0; x.rst = 1'b0;
    x.e_do = 1'b0; x.e_doe = 1'b0; x.e_vld = 1'b0; x.e_perr = 1'b0;
    x.e_wv = 1'b0; x.e_rr = 1'b0;
    x.chk_do = 1'b0; x.chk_cmd = 1'b0; x.e_cmd = 4'h0;
    return x;
  endfunction

  // One clock cycle on one instance: drive, check, then advance the error-count model.
  task automatic run_cyc(input int inst, input cyc_t x);
    logic [7:0] errobs;
    int emax;
    @(posedge dck);
    #1;
    for (int k = 0; k < 3; k++) begin
      di_v[k]  = 1'b0;
      clr_v[k] = 1'b0;
    end
    di_v[inst] = x.di; pend_v[inst] = x.pend; rd_v[inst] = x.rd;
    conn_v[inst] = x.conn; clr_v[inst] = x.clr;
    if (x.rst) drst = 1'b1;
    #3;
    chk("doe_nxt", inst, 8'(doe_v[inst]), 8'(x.e_doe));
    if (x.chk_do) chk("do_nxt", inst, 8'(do_v[inst]), 8'(x.e_do));
    chk("cmd_vld", inst, 8'(vld_v[inst]), 8'(x.e_vld));
    chk("parity_err", inst, 8'(perr_v[inst]), 8'(x.e_perr));
    chk("wdata_vld", inst, 8'(wv_v[inst]), 8'(x.e_wv));
    chk("rdata_rdy", inst, 8'(rr_v[inst]), 8'(x.e_rr));
    chk("wdata", inst, 8'(wd_v[inst]), 8'(x.di));
    if (x.chk_cmd) chk("cmd", inst, 8'(cmd_v[inst]), 8'(x.e_cmd));
    case (inst)
      0:       errobs = err_a;
      1:       errobs = err_b;
      default: errobs = {6'b0, err_c};
    endcase
    chk("err_cnt", inst, errobs, 8'(exp_err[inst]));
    emax = (inst == 2) ? 3 : 255;
`ifdef TWOWIRE_DTM_SERIAL_ERRCNT_EN
    if (x.clr) exp_err[inst] = 0;
    else if (x.e_perr && exp_err[inst] < emax) exp_err[inst]++;
`endif
    if (x.rst) begin
      for (int k = 0; k < 3; k++) exp_err[k] = 0;
      #2;
      drst = 1'b0;
    end
  endtask

  task automatic idle_gap(input int inst, input int gap);
    cyc_t x;
    for (int g = 0; g < gap; g++) begin
      x = blank();
      x.chk_do = 1'b1;
      x.clr = ($urandom_range(0, 7) == 0);
      run_cyc(inst, x);
    end
  endtask

  // Expand one frame into cycles. bits[i] is payload bit i (write) or rdata bit i (read).
  task automatic run_frame(input int inst, input logic [3:0] c, input logic pbit, input int len,
                           input logic [15:0] bits, input bit ppar_flip, input int drop_at,
                           input int rst_at, input bit clr_at_err, input int gap);
    cyc_t x;
    logic ep, acc;
    int nturn, t;
    nturn = (inst == 1) ? 4 : 2;
    x = blank(); x.di = 1'b1; x.chk_do = 1'b1;
    run_cyc(inst, x);
    for (int i = 0; i < 4; i++) begin
      x = blank(); x.di = c[3-i];
      run_cyc(inst, x);
    end
    ep = ~^c;
    x = blank(); x.di = pbit; x.chk_cmd = 1'b1; x.e_cmd = c;
    x.e_vld = (pbit == ep); x.e_perr = (pbit != ep);
    if (pbit != ep) x.clr = clr_at_err;
    run_cyc(inst, x);
    if (pbit != ep) begin
      idle_gap(inst, gap);
      return;
    end
    t = ep ? nturn : nturn - 2;
    for (int i = 0; i < t; i++) begin
      x = blank(); x.di = 1'($urandom); x.chk_cmd = 1'b1; x.e_cmd = c;
      run_cyc(inst, x);
    end
    acc = 1'b1;
    for (int i = 0; i < len; i++) begin
      x = blank(); x.chk_cmd = 1'b1; x.e_cmd = c; x.pend = (i == len - 1);
      if (ep) begin
        x.di = bits[i]; x.e_wv = 1'b1;
      end else begin
        x.rd = bits[i]; x.e_rr = 1'b1; x.e_doe = 1'b1; x.e_do = bits[i]; x.chk_do = 1'b1;
      end
      acc = acc ^ bits[i];
      if (i == drop_at || i == rst_at) begin
        x.e_wv = 1'b0; x.e_rr = 1'b0; x.e_doe = 1'b0; x.e_do = 1'b0; x.chk_do = 1'b1;
        if (i == drop_at) x.conn = 1'b0;
        else begin x.rst = 1'b1; x.e_cmd = 4'h0; end
        run_cyc(inst, x);
        x = blank(); x.chk_do = 1'b1;
        if (i == rst_at) begin x.chk_cmd = 1'b1; x.e_cmd = 4'h0; end
        run_cyc(inst, x);
        idle_gap(inst, gap);
        return;
      end
      run_cyc(inst, x);
    end
    x = blank(); x.chk_cmd = 1'b1; x.e_cmd = c;
    if (ep) begin
      x.di = acc ^ ppar_flip; x.e_perr = ppar_flip;
      if (ppar_flip) x.clr = clr_at_err;
      run_cyc(inst, x);
      if (ppar_flip) begin
        idle_gap(inst, gap);
        return;
      end
    end else begin
      x.e_doe = 1'b1; x.e_do = acc; x.chk_do = 1'b1;
      run_cyc(inst, x);
    end
    x = blank(); x.chk_cmd = 1'b1; x.e_cmd = c;
    if (!ep) begin x.e_doe = 1'b1; x.e_do = 1'b0; x.chk_do = 1'b1; end
    run_cyc(inst, x);
    for (int i = 0; i < nturn; i++) begin
      x = blank(); x.di = 1'($urandom); x.chk_cmd = 1'b1; x.e_cmd = c;
      run_cyc(inst, x);
    end
    idle_gap(inst, gap);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_t x;
    drst = 1'b1; di_v = '0; pend_v = '0; rd_v = '0; conn_v = '1; clr_v = '0;
    for (int k = 0; k < 3; k++) exp_err[k] = 0;
    repeat (2) @(posedge dck);
    #4;
    for (int k = 0; k < 3; k++) begin
      chk("rst_doe", k, 8'(doe_v[k]), 8'h00);
      chk("rst_do", k, 8'(do_v[k]), 8'h00);
      chk("rst_cmd", k, 8'(cmd_v[k]), 8'h00);
      chk("rst_vld", k, 8'(vld_v[k]), 8'h00);
    end
    chk("rst_err", 0, err_a, 8'h00);
    chk("rst_err", 2, {6'b0, err_c}, 8'h00);
    @(negedge dck);
    drst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = blank(); x.chk_do = 1'b1; x.chk_cmd = 1'b1; x.e_cmd = 4'h0;
      run_cyc(k, x);
    end

    // Write 0011, payload A5, good parity.
    run_frame(0, 4'b0011, 1'b1, 8, 16'h00A5, 1'b0, -1, -1, 1'b0, 1);
    // Read 0001, rdata 1,0,1,1 (bit0 first).
    run_frame(0, 4'b0001, 1'b0, 4, 16'b1101, 1'b0, -1, -1, 1'b0, 0);
    // Longer turnaround read.
    run_frame(1, 4'b0001, 1'b0, 3, 16'b101, 1'b0, -1, -1, 1'b0, 1);
    // Command parity error, then immediately a good frame.
    run_frame(0, 4'b0011, 1'b0, 1, 16'h0, 1'b0, -1, -1, 1'b0, 0);
    run_frame(0, 4'b0110, 1'b1, 1, 16'h1, 1'b0, -1, -1, 1'b0, 0);
    // Write payload parity error.
    run_frame(0, 4'b0101, 1'b1, 5, 16'h0013, 1'b1, -1, -1, 1'b0, 1);
    // Saturation: five errors then clear coincident with a sixth.
    for (int e = 0; e < 5; e++) run_frame(2, 4'b0011, 1'b0, 1, 16'h0, 1'b0, -1, -1, 1'b0, 0);
    run_frame(2, 4'b0011, 1'b0, 1, 16'h0, 1'b0, -1, -1, 1'b1, 1);
    // Link drop in 2nd read DATA cycle, then a normal frame.
    run_frame(0, 4'b0001, 1'b0, 4, 16'b1111, 1'b0, 1, -1, 1'b0, 1);
    run_frame(0, 4'b1000, 1'b0, 2, 16'b01, 1'b0, -1, -1, 1'b0, 1);
    // Reset mid-frame during read DATA.
    run_frame(1, 4'b0100, 1'b0, 4, 16'b1111, 1'b0, -1, 2, 1'b0, 1);

    for (int f = 0; f < 75; f++) begin
      int inst, len, dr, ra;
      logic [3:0] c;
      logic pb;
      inst = f % 3;
      c = 4'($urandom);
      pb = ~^c;
      if ($urandom_range(0, 6) == 0) pb = ~pb;
      len = int'($urandom_range(1, 12));
      dr = -1;
      ra = -1;
      if ($urandom_range(0, 9) == 0) dr = int'($urandom_range(0, len - 1));
      else if ($urandom_range(0, 19) == 0) ra = int'($urandom_range(0, len - 1));
      run_frame(inst, c, pb, len, 16'($urandom), ($urandom_range(0, 6) == 0), dr, ra,
                ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/twowire_dtm_serial_comms_param.md
# twowire_dtm_serial_comms_param

Parametrised DTM serial communications unit for the Two-Wire Debug DTM. It frames start/command/parity/turnaround/data/parity sequences on registered DIO, drives the next-cycle DO/DOE pad values, and generates and checks odd parity. It generalises command width and turnaround length, and adds an optional saturating parity-error counter. It sits between the DIO pad registers and the DTM core command decoder.

## Interface
- `W_CMD`, 4: command field width in bits; must be at least 2.
- `N_TURN`, 2: bus turnaround length in DCK cycles; must be at least 2.
- `W_ERRCNT`, 8: parity-error counter width; must be at least 1.

- `dck`  in  1  debug clock; the block has one clock.
- `drst`  in  1  reset, asynchronous, active-high.
- `di_q`  in  1  DIO input, already registered one cycle.
- `do_nxt`  out  1  next DO pad value.
- `doe_nxt`  out  1  next DOE pad value.
- `connected`  in  1  link established; low forces idle.
- `cmd`  out  W_CMD  captured command.
- `cmd_vld`  out  1  single-cycle pulse: command accepted.
- `cmd_payload_end`  in  1  core flags the last payload bit.
- `parity_err`  out  1  single-cycle pulse: parity mismatch.
- `wdata`  out  1  equals `di_q`.
- `wdata_vld`  out  1  write bit valid this cycle.
- `rdata`  in  1  read bit from the core.
- `rdata_rdy`  out  1  read bit consumed this cycle.
- `err_cnt`  out  W_ERRCNT  saturating parity-error count.
- `err_clr`  in  1  clears `err_cnt`.

## Operation
- States:
  - IDLE
  - CMD: counts W_CMD bits.
  - CMD_PARITY
  - CTURN: counted.
  - DATA
  - PARITY
  - PARK
  - TAIL: counts N_TURN cycles.
- One shared down-counter, width `$clog2(max(W_CMD,N_TURN)+1)`.
- IDLE: go to CMD when `di_q`=1 (start bit).
- CMD: shift `di_q` into `cmd` LSB-first-arrival (MSB is the first bit received). Go to CMD_PARITY after W_CMD bits.
- CMD_PARITY:
  - Expected bit is `~^cmd` (odd parity). The command is a write iff the expected bit is 1.
  - On match: pulse `cmd_vld`. A write goes to CTURN for N_TURN cycles. A read goes to CTURN for N_TURN-2 cycles, or directly to DATA when N_TURN=2.
  - On mismatch: pulse `parity_err` and go to IDLE.
- DATA, write: `wdata_vld`=1 and the running parity accumulates `di_q`.
- DATA, read: `rdata_rdy`=1, `doe_nxt`=1, `do_nxt`=`rdata`, and the running parity accumulates `rdata`.
- DATA exit: when `cmd_payload_end`=1, go to PARITY.
- Running parity is 1 in every non-DATA cycle, so payload parity is odd.
- PARITY, write: compare `di_q` with the running parity. On mismatch pulse `parity_err` and go to IDLE; otherwise go to PARK.
- PARITY, read: drive `doe_nxt`=1, `do_nxt`=parity, then go to PARK.
- PARK: a read drives `doe_nxt`=1, `do_nxt`=0. Then go to TAIL.
- TAIL: N_TURN cycles with outputs undriven, then go to IDLE.
- `connected`=0 overrides everything:
  - `state_nxt`=IDLE.
  - `do_nxt`=`doe_nxt`=0 in the same cycle.
  - `cmd_vld` and `parity_err` are still permitted.
- `err_cnt`:
  - Increments on each `parity_err` pulse and saturates at all-ones.
  - `err_clr` has priority: the count becomes 0 on clear. A simultaneous error is dropped.

## Timing
- Reset values:
  - state IDLE, `cmd`=0, running parity 0, `err_cnt`=0.
  - All combinational outputs are 0 in IDLE.
- `cmd_vld`, `parity_err`, `wdata_vld`, `rdata_rdy`, `do_nxt` and `doe_nxt` are combinational from state and inputs.
- `cmd` is registered and stable from `cmd_vld` through return to IDLE.
- Read data latency: the first `rdata_rdy` is N_TURN-1 cycles after `cmd_vld`.
- Write data latency: the first `wdata_vld` is N_TURN+1 cycles after `cmd_vld`.
- Minimum frame: `cmd_payload_end` is allowed in the first DATA cycle, giving a 1-bit payload.
- Reset mid-frame returns to IDLE immediately with DOE released.
- A start bit is recognised only in IDLE. `di_q`=1 during TAIL is ignored.

## Configuration
- `TWOWIRE_DTM_SERIAL_ERRCNT_EN` defined: the error counter is present as described.
- Undefined: `err_cnt` is tied to 0, `err_clr` is ignored, and no counter flops exist. All other behaviour is identical.

## Structure
- Shared `twowire_dtm_pkg` holds the state encoding constants and the parity helper.
- The saturating counter is one sub-module, `twowire_dtm_sat_counter` (parameter W; inputs inc and clr). It is instantiated only under the macro.

## Test plan
All scenarios use W_CMD=4 and N_TURN=2 unless stated, with the macro defined.
1. Write, cmd 4'b0011, parity bit 1:
   - `cmd_vld` pulses at CMD_PARITY with `cmd`=4'h3.
   - Two idle cycles follow.
   - Payload 8'hA5 arrives with `cmd_payload_end` on bit 8 and payload parity 1.
   - Response: 8 `wdata_vld` pulses, no `parity_err`, IDLE after PARK plus 2 TAIL cycles.
2. Read, cmd 4'b0001, parity bit 0:
   - `rdata_rdy` starts the cycle after `cmd_vld`.
   - `rdata` stream 1,0,1,1 with end on bit 4 gives `do_nxt`=1,0,1,1.
   - Then parity 0, then park 0 with `doe_nxt`=1, then `doe_nxt`=0.
3. N_TURN=4 read:
   - The first `rdata_rdy` comes 3 cycles after `cmd_vld`.
   - TAIL lasts 4 cycles.
4. Command parity error: cmd 4'b0011 with parity bit 0.
   - `parity_err` pulses once and `err_cnt` goes 0→1.
   - IDLE next cycle, no `cmd_vld`.
5. Saturation with W_ERRCNT=2:
   - 5 errors give `err_cnt`=3.
   - `err_clr` coincident with a 6th error gives `err_cnt`=0.
6. `connected` dropped in the 2nd read DATA cycle:
   - `doe_nxt`=0 in the same cycle, state IDLE next.
   - A later start bit is accepted normally.
